// File: rtl/chess_pkg.sv
// Shared constants and types for the move gatherer: direction indices,
// word field positions, piece codes and the scan FSM states.
package chess_pkg;
  localparam int NUM_DIRS = 16;
  localparam int NUM_RAYS = 8;
  localparam int NUM_KNIGHTS = 8;

  localparam int DIR_U   = 0;
  localparam int DIR_D   = 1;
  localparam int DIR_L   = 2;
  localparam int DIR_R   = 3;
  localparam int DIR_UL  = 4;
  localparam int DIR_UR  = 5;
  localparam int DIR_DL  = 6;
  localparam int DIR_DR  = 7;
  localparam int DIR_UUL = 8;
  localparam int DIR_UUR = 9;
  localparam int DIR_LLU = 10;
  localparam int DIR_RRU = 11;
  localparam int DIR_DDL = 12;
  localparam int DIR_DDR = 13;
  localparam int DIR_LLD = 14;
  localparam int DIR_RRD = 15;

  localparam int RAY_W         = 11;
  localparam int RAY_VALID_BIT = 10;
  localparam int RAY_FROM_LSB  = 4;
  localparam int RAY_PIECE_LSB = 0;
  localparam int KN_W          = 8;
  localparam int KN_VALID_BIT  = 7;
  localparam int KN_RSVD_BIT   = 6;
  localparam int KN_FROM_LSB   = 0;

  localparam logic [3:0] PIECE_NONE   = 4'd0;
  localparam logic [3:0] PIECE_PAWN   = 4'd1;
  localparam logic [3:0] PIECE_KNIGHT = 4'd2;
  localparam logic [3:0] PIECE_BISHOP = 4'd3;
  localparam logic [3:0] PIECE_ROOK   = 4'd4;
  localparam logic [3:0] PIECE_QUEEN  = 4'd5;
  localparam logic [3:0] PIECE_KING   = 4'd6;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SERIAL, FINISH} state_t;

  typedef struct packed {
    logic [5:0] from;
    logic [5:0] to;
    logic [3:0] piece;
  } move_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [3:0] lowest_set(input logic [NUM_DIRS-1:0] m);
    lowest_set = 4'd0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 4'(i);
    end
  endfunction
endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is read combinationally
// and forced to zero while empty so the outputs are clean after reset.
module move_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/move_gatherer.sv
// Scans all 64 squares through the registered board mux and serializes every
// valid incoming move word into the output FIFO in direction order.
module move_gatherer
  import chess_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  output logic [5:0]   sqSel,
  input  logic [175:0] rayMoves,
  input  logic [127:0] knightMoves,
  output logic         mvValid,
  input  logic         mvReady,
  output logic [5:0]   mvFrom,
  output logic [5:0]   mvTo,
  output logic [3:0]   mvPiece,
  output logic         busy,
  output logic         done,
  output logic [7:0]   moveCount
);
  state_t                state_q, state_d;
  logic [5:0]            sq_idx_q, sq_idx_d;
  logic [NUM_DIRS-1:0]   pending_q, pending_d;
  logic [7:0]            count_q, count_d;
  logic [5:0]            from_q [NUM_DIRS];
  logic [5:0]            from_d [NUM_DIRS];
  logic [3:0]            piece_q [NUM_DIRS];
  logic [3:0]            piece_d [NUM_DIRS];

  logic [5:0]            cap_from [NUM_DIRS];
  logic [3:0]            cap_piece [NUM_DIRS];
  logic [NUM_DIRS-1:0]   cap_valid;

  logic [3:0]            sel;
  logic                  push;
  move_t                 push_data, head;
  logic                  fifo_full, fifo_empty;

  // Bits 0-7 are the ray words, bits 8-15 the knight words, in direction order.
  for (genvar gi = 0; gi < NUM_RAYS; gi++) begin : g_unpack
    logic [RAY_W-1:0] rw;
    logic [KN_W-1:0]  kw;
    logic             unused_rsvd;
    assign rw                     = rayMoves[gi*RAY_W +: RAY_W];
    assign kw                     = knightMoves[gi*KN_W +: KN_W];
    assign cap_valid[gi]          = rw[RAY_VALID_BIT];
    assign cap_from[gi]           = rw[RAY_FROM_LSB +: 6];
    assign cap_piece[gi]          = rw[RAY_PIECE_LSB +: 4];
    assign cap_valid[gi+NUM_RAYS] = kw[KN_VALID_BIT];
    assign cap_from[gi+NUM_RAYS]  = kw[KN_FROM_LSB +: 6];
    assign cap_piece[gi+NUM_RAYS] = PIECE_KNIGHT;
    assign unused_rsvd            = kw[KN_RSVD_BIT];
  end

  always_comb begin
    state_d   = state_q;
    sq_idx_d  = sq_idx_q;
    pending_d = pending_q;
    count_d   = count_q;
    from_d    = from_q;
    piece_d   = piece_q;
    push      = 1'b0;
    sel       = lowest_set(pending_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          sq_idx_d = '0;
          count_d  = '0;
          state_d  = FETCH;
        end
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        from_d    = cap_from;
        piece_d   = cap_piece;
        pending_d = cap_valid;
        state_d   = SERIAL;
      end
      SERIAL: begin
        if (pending_q != '0) begin
          // A full FIFO simply stalls here with the pending mask intact.
          if (!fifo_full) begin
            push           = 1'b1;
            pending_d[sel] = 1'b0;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
          end
        end else if (sq_idx_q == 6'd63) begin
          state_d = FINISH;
        end else begin
          sq_idx_d = sq_idx_q + 6'd1;
          state_d  = FETCH;
        end
      end
      FINISH: begin
        sq_idx_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      sq_idx_q  <= '0;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sq_idx_q  <= sq_idx_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    from_q  <= from_d;
    piece_q <= piece_d;
  end

  assign push_data = '{from: from_q[sel], to: sq_idx_q, piece: piece_q[sel]};

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(move_t))
  ) u_fifo (
    .clk   (clk),
    .srst  (clear),
    .push  (push),
    .wdata (push_data),
    .pop   (mvReady),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mvValid   = !fifo_empty;
  assign mvFrom    = head.from;
  assign mvTo      = head.to;
  assign mvPiece   = head.piece;
  assign sqSel     = sq_idx_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign moveCount = count_q;
endmodule

// File: tb/tb_move_gatherer.sv
// Scoreboard bench: a board model feeds the registered square mux, stimulus
// queues expected moves, and a monitor checks every accepted FIFO head.
module tb_move_gatherer;
  localparam logic [3:0] KNIGHT_CODE = 4'd2;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   sqSel;
  logic [175:0] rayMoves = '0;
  logic [127:0] knightMoves = '0;
  logic         mvValid;
  logic         mvReady = 1'b1;
  logic [5:0]   mvFrom, mvTo;
  logic [3:0]   mvPiece;
  logic         busy, done;
  logic [7:0]   moveCount;

  typedef struct packed {
    logic [5:0] f;
    logic [5:0] t;
    logic [3:0] p;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [10:0] ray_w [64][8];
  logic [7:0]  kn_w  [64][8];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;
  bit          sweep_en = 1'b0;
  int          last_sel = 0;
  int          max_sel = 0;

  move_gatherer #(.FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .sqSel       (sqSel),
    .rayMoves    (rayMoves),
    .knightMoves (knightMoves),
    .mvValid     (mvValid),
    .mvReady     (mvReady),
    .mvFrom      (mvFrom),
    .mvTo        (mvTo),
    .mvPiece     (mvPiece),
    .busy        (busy),
    .done        (done),
    .moveCount   (moveCount)
  );

  always #5 clk = ~clk;

  // Board model: one-cycle registered mux selected by sqSel.
  always @(posedge clk) begin
    for (int d = 0; d < 8; d++) begin
      rayMoves[d*11 +: 11]  <= ray_w[sqSel][d];
      knightMoves[d*8 +: 8] <= kn_w[sqSel][d];
    end
  end

  // Monitor: compare each accepted head against the scoreboard.
  always @(negedge clk) begin
    if (!clear && mvValid && mvReady) begin
      n_pop++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL move_extra: got %0d->%0d p%0d, required no move", mvFrom, mvTo, mvPiece);
      end else begin
        e = exp_q.pop_front();
        if ({mvFrom, mvTo, mvPiece} != e) begin
          n_err++;
          $display("FAIL move: got %0d->%0d p%0d, required %0d->%0d p%0d",
                   mvFrom, mvTo, mvPiece, e.f, e.t, e.p);
        end
      end
    end
    if (sweep_en && busy && int'(sqSel) != last_sel) begin
      n_vec++;
      if (int'(sqSel) != last_sel + 1) begin
        n_err++;
        $display("FAIL sqSel_step: got %0d, required %0d", sqSel, last_sel + 1);
      end
      last_sel = int'(sqSel);
      if (last_sel > max_sel) max_sel = last_sel;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_board();
    for (int s = 0; s < 64; s++)
      for (int d = 0; d < 8; d++) begin
        ray_w[s][d] = '0;
        kn_w[s][d]  = '0;
      end
  endtask

  // Fill the first n directions of square s with valid, distinct words;
  // odd knight words also carry the reserved bit.
  task automatic fill_square(input int s, input int n);
    logic [5:0] f;
    for (int d = 0; d < n; d++) begin
      if (d < 8) begin
        f = 6'((s * 7 + d * 5 + 1) % 64);
        ray_w[s][d] = {1'b1, f, 4'(d % 6 + 1)};
      end else begin
        f = 6'((s * 3 + d) % 64);
        kn_w[s][d-8] = {1'b1, 1'(d % 2), f};
      end
    end
  endtask

  // Queue the expected move list in scan order for the current board.
  task automatic expect_board();
    for (int s = 0; s < 64; s++) begin
      for (int d = 0; d < 8; d++)
        if (ray_w[s][d][10]) exp_q.push_back({ray_w[s][d][9:4], 6'(s), ray_w[s][d][3:0]});
      for (int d = 0; d < 8; d++)
        if (kn_w[s][d][7]) exp_q.push_back({kn_w[s][d][5:0], 6'(s), KNIGHT_CODE});
    end
  endtask

  // Pulse start, count cycles until done (start-capture edge is cycle 0).
  task automatic run_scan(input string tag, input int exp_cyc, input int exp_cnt);
    int cyc;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_first_sq"}, int'(sqSel), 0);
      end
    end while (!done && cyc < 5000);
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done after %0d cycles, required done", tag, cyc);
    end else if (exp_cyc > 0) begin
      chk({tag, "_done_cycle"}, cyc, exp_cyc);
    end
    chk({tag, "_count"}, int'(moveCount), exp_cnt);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_empty"}, int'(mvValid), 0);
  endtask

  initial begin
    int k;
    int pop0;
    clear_board();
    repeat (3) @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("rst_sqSel", int'(sqSel), 0);
    chk("rst_mvValid", int'(mvValid), 0);
    chk("rst_mvFrom", int'(mvFrom), 0);
    chk("rst_mvTo", int'(mvTo), 0);
    chk("rst_mvPiece", int'(mvPiece), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(moveCount), 0);

    // Empty board: 64 x 3 + 1 cycles, full sqSel sweep, no moves.
    last_sel = 0; max_sel = 0; sweep_en = 1'b1;
    run_scan("empty", 193, 0);
    sweep_en = 1'b0;
    chk("empty_max_sq", max_sel, 63);

    // Square 12: U = 0x4B3 and UUL = 0x81; a stray start mid-scan is ignored.
    ray_w[12][0] = 11'h4B3;
    kn_w[12][0]  = 8'h81;
    exp_q.push_back({6'd11, 6'd12, 4'd3});
    exp_q.push_back({6'd1, 6'd12, KNIGHT_CODE});
    fork
      run_scan("sq12", 195, 2);
      begin
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    drain("sq12");

    // Back-pressure: 64 moves with the consumer stalled for 100 cycles.
    clear_board();
    for (int s = 0; s < 4; s++) fill_square(s, 16);
    expect_board();
    mvReady = 1'b0;
    fork
      run_scan("bp", 0, 64);
      begin
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("bp_stall_count", int'(moveCount), 16);
        chk("bp_stall_busy", int'(busy), 1);
        chk("bp_stall_valid", int'(mvValid), 1);
        @(posedge clk); #1 mvReady = 1'b1;
      end
    join
    drain("bp");

    // Clear in SERIAL with 5 entries queued, then a fresh scan from square 0.
    clear_board();
    fill_square(0, 8);
    exp_q.delete();
    mvReady = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (moveCount != 8'd5 && k < 100);
    chk("clr_reach5", int'(moveCount), 5);
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 clear = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("clr_mvValid", int'(mvValid), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_count", int'(moveCount), 0);
    chk("clr_sqSel", int'(sqSel), 0);
    mvReady = 1'b1;
    expect_board();
    run_scan("rescan", 201, 8);
    drain("rescan");

    // 300 moves: count saturates at 255, every move still delivered.
    clear_board();
    for (int s = 0; s < 18; s++) fill_square(s, 16);
    fill_square(18, 12);
    expect_board();
    pop0 = n_pop;
    run_scan("sat", 493, 255);
    drain("sat");
    chk("sat_delivered", n_pop - pop0, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end
endmodule
